// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_abs.sv
// Combinational two's-complement helper: passes value through, or negates it when negate_en is set.
module div_abs #(
  parameter int W = div_pkg::WIDTH
) (
  input  logic [W-1:0] value,
  input  logic         negate_en,
  output logic [W-1:0] result
);
  import div_pkg::*;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign result = negate_en ? (~value + ONE) : value;

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, quotient -> LO, remainder -> HI.
// Optional build macro DIV_EARLY_OUT_EN: zero dividend or divisor finishes one cycle after start.
module div_iter #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  import div_pkg::*;

  localparam int               STEPS = WIDTH;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

  div_state_e       state_r, next_state_s;
  logic             load_s, fix_s, early_s, early_cond_s;
  logic [WIDTH-1:0] rem_r, dvd_r, dsr_r;
  logic [CNT_W-1:0] count_r;
  logic             neg_q_r, neg_r_r, dz_r;
  logic [WIDTH-1:0] dvd_mag_s, dsr_mag_s, q_fix_s, r_fix_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH-1:0] diff_s, step_rem_s;
  logic             q_bit_s, dsr_zero_s;

  logic             busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  assign dsr_zero_s = (divisor == ZERO);

`ifdef DIV_EARLY_OUT_EN
  assign early_cond_s = dsr_zero_s || (dividend == ZERO);
`else
  assign early_cond_s = 1'b0;
`endif

  div_abs #(.W(WIDTH)) u_abs_dvd (
    .value     (dividend),
    .negate_en (sign & dividend[WIDTH-1]),
    .result    (dvd_mag_s)
  );

  div_abs #(.W(WIDTH)) u_abs_dsr (
    .value     (divisor),
    .negate_en (sign & divisor[WIDTH-1]),
    .result    (dsr_mag_s)
  );

  div_abs #(.W(WIDTH)) u_fix_q (
    .value     (dvd_r),
    .negate_en (neg_q_r),
    .result    (q_fix_s)
  );

  // With a zero divisor the remainder equals |dividend|, so restoring its sign recovers the original.
  div_abs #(.W(WIDTH)) u_fix_r (
    .value     (rem_r),
    .negate_en (neg_r_r),
    .result    (r_fix_s)
  );

  // One restoring step: the true difference is below 2^WIDTH whenever it is kept, so WIDTH bits suffice.
  assign shift_s    = {rem_r, dvd_r[WIDTH-1]};
  assign q_bit_s    = (shift_s >= {1'b0, dsr_r});
  assign diff_s     = shift_s[WIDTH-1:0] - dsr_r;
  assign step_rem_s = q_bit_s ? diff_s : shift_s[WIDTH-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    fix_s        = 1'b0;
    early_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (early_cond_s) begin
            next_state_s = DONE;
            early_s      = 1'b1;
          end else begin
            next_state_s = RUN;
            load_s       = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST) begin
          next_state_s = FIX;
        end else begin
          next_state_s = RUN;
        end
      end
      FIX: begin
        next_state_s = DONE;
        fix_s        = 1'b1;
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand capture and the iterating partial remainder / quotient shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r   <= ZERO;
      dvd_r   <= ZERO;
      dsr_r   <= ZERO;
      count_r <= {CNT_W{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else if (load_s) begin
      rem_r   <= ZERO;
      dvd_r   <= dvd_mag_s;
      dsr_r   <= dsr_mag_s;
      count_r <= {CNT_W{1'b0}};
      neg_q_r <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_r <= sign & dividend[WIDTH-1];
      dz_r    <= dsr_zero_s;
    end else if (state_r == RUN) begin
      rem_r   <= step_rem_s;
      dvd_r   <= {dvd_r[WIDTH-2:0], q_bit_s};
      count_r <= count_r + CNT_ONE;
    end else begin
      rem_r   <= rem_r;
      dvd_r   <= dvd_r;
      count_r <= count_r;
    end
  end

  // Handshake and result registers; results move only on reset, in FIX, or on an early-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= ZERO;
      remainder_r <= ZERO;
      div_zero_r  <= 1'b0;
    end else begin
      busy_r <= (next_state_s == RUN) || (next_state_s == FIX);
      done_r <= (next_state_s == DONE);
      if (fix_s) begin
        quotient_r  <= dz_r ? ONES : q_fix_s;
        remainder_r <= r_fix_s;
        div_zero_r  <= dz_r;
      end else if (early_s) begin
        quotient_r  <= dsr_zero_s ? ONES : ZERO;
        remainder_r <= dsr_zero_s ? dividend : ZERO;
        div_zero_r  <= dsr_zero_s;
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
        div_zero_r  <= div_zero_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed operations with a scoreboard of expected results.
module tb_div_iter;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_Z = 1;
`else
  localparam int LAT_Z = 34;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, sign;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the arithmetic rules.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Called just before a rising edge with the DUT in IDLE; returns #1 after the start edge.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    sign = s; dividend = a; divisor = b; start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    sign = ~s; dividend = $urandom; divisor = $urandom;
  endtask

  // Waits (bounded) for done, checking latency, busy and the scoreboard head; leaves us at that negedge.
  task automatic wait_done(input string tag, input int exp_lat);
    int   cyc;
    logic busy_ok, seen;
    exp_t e;
    cyc = 0; busy_ok = 1'b1; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, " done_seen"}, seen, 32'd1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy_while_running"}, busy_ok, 32'd1);
    check({tag, " busy_at_done"}, busy, 32'd0);
    check({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " quotient"}, quotient, e.q);
      check({tag, " remainder"}, remainder, e.r);
      check({tag, " div_zero"}, div_zero, e.dz);
    end
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic        s, dz, seen;
    exp_t        e;

    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 32'd0);
    check("reset done", done, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_zero", div_zero, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done("u100_7", 34);
    repeat (3) @(negedge clk);
    check("u100_7 held quotient", quotient, 32'd14);

    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_done("s-7_2", 34);
    @(negedge clk);
    launch(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_done("s7_-2", 34);
    @(negedge clk);
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    wait_done("s_ovf", 34);
    @(negedge clk);
    launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    wait_done("u_ovf", 34);
    @(negedge clk);
    launch(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    wait_done("s_dz", LAT_Z);
    @(negedge clk);
    launch(1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1);
    wait_done("s_dz_neg", LAT_Z);
    @(negedge clk);
    launch(1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    wait_done("s_zero_dvd", LAT_Z);
    @(negedge clk);

    // A start pulse mid-operation must be ignored.
    launch(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    sign = 1'b1; dividend = 32'd55; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_mid", 29);

    // start raised while done is high is ignored; held into the next (IDLE) cycle it is accepted.
    sign = 1'b0; dividend = 32'd50; divisor = 32'd8; start = 1'b1;
    e.q = 32'd6; e.r = 32'd2; e.dz = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    check("start_in_done busy", busy, 32'd0);
    check("start_in_done done", done, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd1;
    wait_done("after_done", 34);
    @(negedge clk);

    // Reset in the middle of an operation aborts it with no result and no done pulse.
    launch(1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst busy", busy, 32'd0);
    check("mid_rst done", done, 32'd0);
    check("mid_rst quotient", quotient, 32'd0);
    check("mid_rst remainder", remainder, 32'd0);
    sb.delete();
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("mid_rst no_done", seen, 32'd0);
    launch(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    wait_done("post_rst", 34);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      s = i[0];
      model(s, a, b, q, r, dz);
      launch(s, a, b, q, r, dz);
      wait_done("random", (a == 32'd0 || b == 32'd0) ? LAT_Z : 34);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
